// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response constants and the byte-lane enable helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Little-endian lane mask for up to 8 lanes; a misaligned offset is rounded
  // down to the transfer size, sizes above DWORD enable every lane.
  function automatic logic [7:0] byte_enable(input logic [2:0] size, input logic [2:0] addr_lsb);
    logic [7:0] base;
    logic [2:0] align;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    align = addr_lsb & ~(3'b111 >> (3'd3 - ((size > 3'd3) ? 3'd3 : size)));
    return base << align;
  endfunction

endpackage

// File: rtl/ahb_subordinate_ram_mem.sv
// Byte-enabled storage array: one synchronous write port, asynchronous read by index.
module ahb_subordinate_ram_mem #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned DepthWords = 1024
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [DataWidth/8-1:0]        be_i,
  input  logic [$clog2(DepthWords)-1:0] widx_i,
  input  logic [DataWidth-1:0]          wdata_i,
  input  logic [$clog2(DepthWords)-1:0] ridx_i,
  output logic [DataWidth-1:0]          rdata_o
);

  logic [DataWidth-1:0] mem_q [DepthWords];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < DataWidth / 8; b++) begin
        if (be_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/ahb_subordinate_ram.sv
// AHB-Lite subordinate RAM with configurable wait states.
// Define AHB_SUBORDINATE_RAM_ERROR_EN for range/alignment/size ERROR responses.
module ahb_subordinate_ram
  import ahb_pkg::*;
#(
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MemDepthWords = 1024,
  parameter int unsigned WaitStates    = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [AddressWidth-1:0] HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [DataWidth-1:0]    HWDATA,
  input  logic                    HREADY,
  output logic [DataWidth-1:0]    HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP
);

  localparam int unsigned ByteLanes = DataWidth / 8;
  localparam int unsigned LaneBits  = $clog2(ByteLanes);
  localparam int unsigned IdxBits   = $clog2(MemDepthWords);
  localparam logic [2:0]  MaxSize   = 3'(LaneBits);
  localparam logic [3:0]  WaitLoad  = 4'(WaitStates);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA
`ifdef AHB_SUBORDINATE_RAM_ERROR_EN
    , ST_ERR1,
    ST_ERR2
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IdxBits-1:0]   idx_q, idx_d;
  logic [ByteLanes-1:0] be_q, be_d;
  logic                 write_q, write_d;
  logic [DataWidth-1:0] hrdata_q, mem_rdata;
  logic                 ready, resp, mem_we, rd_fire, accept;
  logic [2:0]           size_eff, lsb;
  logic [7:0]           be_full;
  logic                 unused_bits;

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign lsb      = 3'(HADDR[LaneBits-1:0]);
  assign size_eff = (HSIZE > MaxSize) ? MaxSize : HSIZE;
  assign be_full  = byte_enable(size_eff, lsb);

`ifdef AHB_SUBORDINATE_RAM_ERROR_EN
  logic       addr_oor, addr_err;
  logic [2:0] align_mask;

  if (AddressWidth > LaneBits + IdxBits) begin : g_oor
    assign addr_oor = |HADDR[AddressWidth-1:LaneBits+IdxBits];
  end else begin : g_no_oor
    assign addr_oor = 1'b0;
  end

  assign align_mask = ~(3'b111 << HSIZE);
  assign addr_err   = addr_oor | (HSIZE > MaxSize) | (|(lsb & align_mask));
`endif

  assign unused_bits = ^{HADDR, HTRANS[0], be_full};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    mem_we  = 1'b0;
    rd_fire = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        ready = 1'b0;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DATA;
      end
      ST_DATA: begin
        mem_we  = write_q;
        rd_fire = !write_q;
      end
`ifdef AHB_SUBORDINATE_RAM_ERROR_EN
      ST_ERR1: begin
        ready   = 1'b0;
        resp    = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: resp = HRESP_ERROR;
`endif
      default: ;
    endcase
    // Any cycle that ends a data phase may also accept the next address phase.
    if (ready) begin
      state_d = ST_IDLE;
      if (accept) begin
        idx_d   = HADDR[LaneBits +: IdxBits];
        be_d    = be_full[ByteLanes-1:0];
        write_d = HWRITE;
`ifdef AHB_SUBORDINATE_RAM_ERROR_EN
        if (addr_err) begin
          state_d = ST_ERR1;
          write_d = 1'b0;
        end else
`endif
        if (WaitLoad != '0) begin
          state_d = ST_WAIT;
          cnt_d   = WaitLoad;
        end else begin
          state_d = ST_DATA;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      write_q <= write_d;
      if (rd_fire) hrdata_q <= mem_rdata;
    end
  end

  ahb_subordinate_ram_mem #(
    .DataWidth (DataWidth),
    .DepthWords(MemDepthWords)
  ) u_mem (
    .clk_i  (HCLK),
    .we_i   (mem_we),
    .be_i   (be_q),
    .widx_i (idx_q),
    .wdata_i(HWDATA),
    .ridx_i (idx_q),
    .rdata_o(mem_rdata)
  );

  assign HRDATA    = rd_fire ? mem_rdata : hrdata_q;
  assign HREADYOUT = ready;
  assign HRESP     = resp;

endmodule

// File: tb/tb_ahb_subordinate_ram.sv
// Self-checking bench: a zero-wait and a three-wait instance against a byte-array memory model.
module tb_ahb_subordinate_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  ahb_subordinate_ram #(.AddressWidth(32), .DataWidth(32), .MemDepthWords(1024), .WaitStates(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  ahb_subordinate_ram #(.AddressWidth(32), .DataWidth(32), .MemDepthWords(1024), .WaitStates(3)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory: bytes 0..63 (words 0..15) of each instance.
  logic [7:0] model [2][64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] model_word(input int d, input int unsigned a);
    int unsigned w = (a / 4) % 16;
    return {model[d][w*4+3], model[d][w*4+2], model[d][w*4+1], model[d][w*4]};
  endfunction

  function automatic void model_write(input int d, input int unsigned sz, input int unsigned a,
                                      input logic [31:0] data);
    int unsigned n    = 1 << ((sz > 2) ? 2 : sz);
    int unsigned base = a - (a % n);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned ba = base + k;
      model[d][ba % 64] = data[8*(ba%4) +: 8];
    end
  endfunction

  // One isolated transfer; entered and left just after a rising edge.
  task automatic xfer(input int d, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic resp,
                      output int waits, output logic first_wait_resp);
    hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
    @(posedge clk); #1;
    hsel[d] = 1'b0; htrans[d] = 2'b00;
    hwdata[d] = $urandom;
    waits = 0;
    first_wait_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (hreadyout[d]) begin
        hwdata[d] = wd;
        break;
      end
      if (waits == 0) first_wait_resp = hresp[d];
      waits++;
      if (waits > 40) begin
        check("ready_timeout", {31'b0, hreadyout[d]}, 32'd1);
        break;
      end
    end
    rd   = hrdata[d];
    resp = hresp[d];
    @(posedge clk); #1;
    hwdata[d] = $urandom;
  endtask

  task automatic bus_write(input int d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] data);
    logic [31:0] rd;
    logic        resp, fwr;
    int          waits;
    xfer(d, 1'b1, sz, a, data, rd, resp, waits, fwr);
    check("wr_resp", {31'b0, resp}, 32'd0);
    check("wr_waits", waits, ws(d));
    model_write(d, sz, a, data);
  endtask

  task automatic bus_read(input int d, input logic [2:0] sz, input logic [31:0] a, input string tag);
    logic [31:0] rd;
    logic        resp, fwr;
    int          waits;
    xfer(d, 1'b0, sz, a, 32'h0, rd, resp, waits, fwr);
    check(tag, rd, model_word(d, a));
    check("rd_resp", {31'b0, resp}, 32'd0);
    check("rd_waits", waits, ws(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, data, a;
    logic        resp, fwr;
    logic [2:0]  sz;
    int          waits;

    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00; hwrite[d] = 1'b0; hsize[d] = 3'd2; hwdata[d] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    for (int d = 0; d < 2; d++) begin
      check("rst_hreadyout", {31'b0, hreadyout[d]}, 32'd1);
      check("rst_hresp", {31'b0, hresp[d]}, 32'd0);
      check("rst_hrdata", hrdata[d], 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) bus_write(d, 3'd2, 32'(w * 4), $urandom);

    // Word write then read, zero wait states.
    bus_write(0, 3'd2, 32'h10, 32'hDEADBEEF);
    xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, resp, waits, fwr);
    check("rd_deadbeef", rd, 32'hDEADBEEF);
    check("rd_deadbeef_waits", waits, 0);

    // Byte write on lane 3.
    bus_write(0, 3'd2, 32'h10, 32'h11223344);
    bus_write(0, 3'd0, 32'h13, 32'hAA000000);
    xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, resp, waits, fwr);
    check("rd_byte_merge", rd, 32'hAA223344);

    // Three wait states.
    bus_write(1, 3'd2, 32'h18, 32'hCAFEF00D);
    xfer(1, 1'b0, 3'd2, 32'h18, 32'h0, rd, resp, waits, fwr);
    check("ws3_waits", waits, 3);
    check("ws3_rdata", rd, 32'hCAFEF00D);

    // Back-to-back write then read of the same word, no bubble.
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h20; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    @(posedge clk); #1;
    hwrite[0] = 1'b0; hwdata[0] = 32'h55;
    @(negedge clk);
    check("b2b_wr_ready", {31'b0, hreadyout[0]}, 32'd1);
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = $urandom;
    @(negedge clk);
    check("b2b_rd_ready", {31'b0, hreadyout[0]}, 32'd1);
    check("b2b_rdata", hrdata[0], 32'h55);
    model_write(0, 2, 32'h20, 32'h55);
    @(posedge clk); #1;
    @(negedge clk);
    check("rdata_hold", hrdata[0], 32'h55);
    @(posedge clk); #1;

    // Access beyond the RAM.
    xfer(0, 1'b0, 3'd2, 32'h1000, 32'h0, rd, resp, waits, fwr);
`ifdef AHB_SUBORDINATE_RAM_ERROR_EN
    check("err1_resp", {31'b0, fwr}, 32'd1);
    check("err_waits", waits, 1);
    check("err2_resp", {31'b0, resp}, 32'd1);
    bus_read(0, 3'd2, 32'h0, "err_ram_unchanged");
`else
    check("wrap_rdata", rd, model_word(0, 0));
    check("wrap_resp", {31'b0, resp}, 32'd0);
    check("wrap_waits", waits, 0);
    bus_write(0, 3'd1, 32'h31, 32'h1234BBCC);
    bus_read(0, 3'd2, 32'h30, "misalign_half");
    bus_write(0, 3'd3, 32'h2A, 32'h87654321);
    bus_read(0, 3'd2, 32'h28, "oversize_write");
`endif

    // Reset during the wait phase of a write.
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h14; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h0BADF00D;
    @(negedge clk);
    check("rst_wait_low", {31'b0, hreadyout[1]}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hreadyout", {31'b0, hreadyout[1]}, 32'd1);
    check("midrst_hresp", {31'b0, hresp[1]}, 32'd0);
    check("midrst_hrdata", hrdata[1], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus_read(1, 3'd2, 32'h14, "rst_write_dropped");

    // Randomized traffic against the model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
`ifdef AHB_SUBORDINATE_RAM_ERROR_EN
        sz = 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 63));
        a  = a & ~((32'd1 << sz) - 32'd1);
`else
        sz = 3'($urandom_range(0, 3));
        a  = 32'($urandom_range(0, 63));
`endif
        data = $urandom;
        if ($urandom_range(0, 1) == 1) bus_write(d, sz, a, data);
        else bus_read(d, sz, a, "rand_rdata");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_subordinate_ram.md
# ahb_subordinate_ram

Synthesizable AHB-Lite subordinate backed by a byte-writable on-chip RAM, with configurable wait states and a two-cycle ERROR response. It sits directly downstream of `ahb_manager_synth` in the simulation top, in the slot the Renode subordinate bridge otherwise occupies. It lets the manager be exercised against a local, deterministic memory model without a Renode connection.

## Interface
- `AddressWidth`, 32: HADDR width.
- `DataWidth`, 32: HWDATA/HRDATA width; 32 or 64.
- `MemDepthWords`, 1024: RAM depth in DataWidth words; power of two.
- `WaitStates`, 0: extra data-phase cycles per transfer (0..15).
- `HCLK` input 1: clock; all state on rising edge.
- `HRESETn` input 1: asynchronous, active-low reset.
- `HSEL` input 1: subordinate select.
- `HADDR` input AddressWidth: byte address.
- `HTRANS` input 2: IDLE/BUSY/NONSEQ/SEQ.
- `HWRITE` input 1: 1 = write.
- `HSIZE` input 3: transfer size, log2 bytes.
- `HWDATA` input DataWidth: write data, data phase.
- `HREADY` input 1: bus-level ready (from interconnect; equal to HREADYOUT in a single-subordinate system).
- `HRDATA` output DataWidth: read data.
- `HREADYOUT` output 1: this subordinate's data-phase ready.
- `HRESP` output 1: 0 = OKAY, 1 = ERROR.

## Operation
- Address phase is accepted when `HSEL && HREADY && HTRANS[1]`. On acceptance, register addr, write, size, and valid. IDLE/BUSY, or HSEL=0, give a zero-wait OKAY data phase with no access.
- Word index = `HADDR[log2(DataWidth/8) +: log2(MemDepthWords)]`. Byte lanes are little-endian; byte-enable mask is derived from HSIZE and the low address bits.
- FSM states:
  - **IDLE**: no pending data phase. HREADYOUT=1, HRESP=0.
  - **WAIT**: counter loaded with WaitStates on acceptance, decrements each cycle. HREADYOUT=0 while counter ≠ 0. Enter only if WaitStates>0.
  - **DATA**: final data-phase cycle. HREADYOUT=1.
    - Write: the enabled lanes of HWDATA commit at the closing edge.
    - Read: HRDATA = mem[idx_q], full word, all lanes.
  - **ERR1**: HRESP=1, HREADYOUT=0.
  - **ERR2**: HRESP=1, HREADYOUT=1. No memory access on an errored transfer.
- From DATA or ERR2, a transfer accepted in the same cycle goes straight to WAIT, DATA, or ERR1. Back-to-back NONSEQ/SEQ run with no bubble when WaitStates=0.
- Read-after-write to the same word in consecutive transfers returns the new data. The write commits at the edge that opens the read's data phase.
- HRDATA holds its last value outside read DATA cycles. It is 0 after reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0. RAM contents are not reset.
- Asserting HRESETn mid-transfer aborts it. A pending write is dropped.
- Read latency: data valid at edge N+1+WaitStates after the address-phase edge N.
- Error: always exactly two cycles (ERR1, then ERR2), independent of WaitStates.
- HWDATA is sampled only at the DATA-cycle closing edge.

## Configuration
- `AHB_SUBORDINATE_RAM_ERROR_EN` defined:
  - ERROR response when the address is outside `MemDepthWords*DataWidth/8` bytes.
  - ERROR response when the address is misaligned to HSIZE.
  - ERROR response when HSIZE exceeds the bus width.
- `AHB_SUBORDINATE_RAM_ERROR_EN` undefined:
  - No ERR1/ERR2 states.
  - Addresses wrap modulo RAM size.
  - Misaligned addresses are force-aligned down.
  - Oversize transfers are treated as full-width.
  - HRESP is tied to 0.

## Structure
- Shared package `ahb_pkg`:
  - `htrans_e` (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - `hsize_e` (BYTE=0, HALF=1, WORD=2, DWORD=3).
  - HRESP constants OKAY/ERROR.
  - Function `byte_enable(size, addr_lsb)`.
- Sub-module `ahb_subordinate_ram_mem`: byte-enabled storage array, one write port, asynchronous read by index.

## Test plan
- Write word 0xDEADBEEF to 0x10, then read 0x10 with WaitStates=0 -> HRDATA=0xDEADBEEF one cycle after the address phase; HREADYOUT never low.
- Byte write 0xAA to 0x13 over word 0x11223344 -> readback 0xAA223344.
- WaitStates=3, read -> HREADYOUT low for exactly 3 cycles, then data with HREADYOUT=1.
- Back-to-back write 0x55 then read of the same word 0x20 with no bubble -> read returns 0x55.
- ERROR_EN, read at 0x1000 with depth 1024×32 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, RAM unchanged. Without the macro, the same read returns the contents of word 0.
- HRESETn pulsed low during WAIT of a write -> outputs return to reset values immediately; the target word is unchanged.
